cpu: RTL and testbench

Single-cycle RV32I processor core with an embedded unified instruction/data memory; it is the top of the core hierarchy. Each clock edge after reset retires exactly one instruction. The core fetches from, loads from and stores to the internal memory instance. Benches preload the memory hierarchically before reset is released and observe state hierarchically; the block has no data ports.

---
 rtl/cpu.sv | 247 ++++++++++++++++++++++++
 tb/tb_cpu.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Single-cycle RV32I core with an embedded unified instruction/data memory.
// One instruction retires on every rising clock edge that is not a reset edge.

module cpu_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] iaddr,
    output logic [31:0]   idata,
    input  logic [AW-1:0] daddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata
);

    reg [31:0] ramdata [0:MEM_WORDS-1];

    assign idata = ramdata[iaddr];
    assign rdata = ramdata[daddr];

    // Plain always so the array stays loadable from outside (hex preload, benches).
    always @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ramdata[daddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

module cpu #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic clr
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] regs [0:31];

    logic [31:0] instr;
    logic [31:0] rdata;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] next_pc;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] addr;
    logic        store_en;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        take;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    wire unused_addr_bits = &{1'b0, addr[31:AW+2]};

    cpu_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) Memory (
        .clk   (clk),
        .iaddr (pc[AW+1:2]),
        .idata (instr),
        .daddr (addr[AW+1:2]),
        .rdata (rdata),
        .we    (store_en & ~clr),
        .be    (be),
        .wdata (wdata)
    );

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'b0, $signed(a) < $signed(b)};
            3'd3:    r = {31'b0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Branch condition, byte/half lane selection for loads.
    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rs1_val == rs2_val);
            3'b001:  take = (rs1_val != rs2_val);
            3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  take = (rs1_val < rs2_val);
            3'b111:  take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase

        ld_byte = rdata[7:0];
        case (addr[1:0])
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Decode/execute: unrecognised encodings fall through as pc+4 with no writes.
    always_comb begin
        next_pc  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_data  = 32'd0;
        addr     = rs1_val + imm_i;
        store_en = 1'b0;
        be       = 4'b0000;
        wdata    = rs2_val;

        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_data = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (take) begin
                    next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000: begin rd_we = 1'b1; rd_data = {{24{ld_byte[7]}}, ld_byte}; end
                    3'b001: begin rd_we = 1'b1; rd_data = {{16{ld_half[15]}}, ld_half}; end
                    3'b010: begin rd_we = 1'b1; rd_data = rdata; end
                    3'b100: begin rd_we = 1'b1; rd_data = {24'b0, ld_byte}; end
                    3'b101: begin rd_we = 1'b1; rd_data = {16'b0, ld_half}; end
                    default: rd_we = 1'b0;
                endcase
            end
            OP_STORE: begin
                addr = rs1_val + imm_s;
                case (funct3)
                    3'b000: begin
                        store_en = 1'b1;
                        be       = 4'b0001 << addr[1:0];
                        wdata    = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        store_en = 1'b1;
                        be       = addr[1] ? 4'b1100 : 4'b0011;
                        wdata    = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        store_en = 1'b1;
                        be       = 4'b1111;
                    end
                    default: store_en = 1'b0;
                endcase
            end
            OP_IMM: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, (funct3 == 3'd5) & instr[30], rs1_val, imm_i);
            end
            OP_REG: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, instr[30], rs1_val, rs2_val);
            end
            default: begin
                rd_we = 1'b0;
            end
        endcase
    end

    // Architectural state; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc <= next_pc;
            if (rd_we && (rd != 5'd0)) begin
                regs[rd] <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the single-cycle RV32I core: directed programs plus
// randomized ALU/memory programs checked against an instruction-level model.

module tb_cpu;

   logic clk;
   logic clr;

   int totalChecks = 0;
   int passedChecks = 0;

   logic [31:0] prog[$];

   cpu #(
      .MEM_WORDS (1024),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk (clk),
      .clr (clr)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] sext12(input logic [11:0] x);
      return {{20{x[11]}}, x};
   endfunction

   // Reference ALU written from the instruction definitions.
   function automatic logic [31:0] refAlu(input int f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (f3)
         0: return alt ? a - b : a + b;
         1: return a << sh;
         2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3: return (a < b) ? 32'd1 : 32'd0;
         4: return a ^ b;
         5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
         6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // Holds reset for two edges while the memory is cleared and the program loaded.
   task automatic startProgram();
      clr = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 1024; i++) dut.Memory.ramdata[i] = 32'd0;
      for (int i = 0; i < prog.size(); i++) dut.Memory.ramdata[i] = prog[i];
      repeat (2) @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      prog.delete();
      prog.push_back(encI(12'h055, 5'd0, 3'd0, 5'd1, 7'h13));
      prog.push_back(encI(12'h007, 5'd0, 3'd0, 5'd2, 7'h13));
      prog.push_back(encS(12'h200, 5'd1, 5'd0, 3'd2));
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      startProgram();
      step(2);
      clr = 1'b1;
      step(1);
      totalChecks++;
      if (dut.Memory.ramdata[128] !== 32'd0)
         $display("[TB] FAIL store_abort: got %h want %h", dut.Memory.ramdata[128], 32'd0);
      else passedChecks++;
      totalChecks++;
      if (dut.pc !== 32'd0) $display("[TB] FAIL reset_pc: got %h want %h", dut.pc, 32'd0);
      else passedChecks++;
      for (int i = 0; i < 32; i++) begin
         totalChecks++;
         if (dut.regs[i] !== 32'd0)
            $display("[TB] FAIL reset_x%0d: got %h want %h", i, dut.regs[i], 32'd0);
         else passedChecks++;
      end
      totalChecks++;
      if (dut.Memory.ramdata[0] !== prog[0])
         $display("[TB] FAIL mem_preserved: got %h want %h", dut.Memory.ramdata[0], prog[0]);
      else passedChecks++;
      step(1);
      clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         totalChecks++;
         if (dut.pc !== 32'(4 * k))
            $display("[TB] FAIL release_pc%0d: got %h want %h", k, dut.pc, 32'(4 * k));
         else passedChecks++;
         step(1);
      end
      totalChecks++;
      if (dut.regs[1] !== 32'h55) $display("[TB] FAIL release_x1: got %h want %h", dut.regs[1], 32'h55);
      else passedChecks++;
   endtask

   task automatic test_alu();
      logic [31:0] want [0:6];
      $display("[TB] test_alu");
      prog.delete();
      prog.push_back(encI(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
      prog.push_back(encI(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13));
      prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));
      prog.push_back(encR(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33));
      prog.push_back(encI(12'h401, 5'd2, 3'd5, 5'd5, 7'h13));
      prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'd3, 5'd6, 7'h33));
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      want = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'hFFFF_FFFE, 32'd1};
      startProgram();
      step(8);
      for (int i = 1; i < 7; i++) begin
         totalChecks++;
         if (dut.regs[i] !== want[i])
            $display("[TB] FAIL alu_x%0d: got %h want %h", i, dut.regs[i], want[i]);
         else passedChecks++;
      end
   endtask

   task automatic test_load_store();
      logic [31:0] want [0:8];
      $display("[TB] test_load_store");
      prog.delete();
      prog.push_back(encU(20'h12345, 5'd1, 7'h37));
      prog.push_back(encI(12'h678, 5'd1, 3'd0, 5'd1, 7'h13));
      prog.push_back(encS(12'h100, 5'd1, 5'd0, 3'd2));
      prog.push_back(encI(12'h100, 5'd0, 3'd0, 5'd2, 7'h03));
      prog.push_back(encI(12'h102, 5'd0, 3'd5, 5'd3, 7'h03));
      prog.push_back(encS(12'h101, 5'd0, 5'd0, 3'd0));
      prog.push_back(encI(12'h100, 5'd0, 3'd2, 5'd4, 7'h03));
      prog.push_back(encI(12'h080, 5'd0, 3'd0, 5'd5, 7'h13));
      prog.push_back(encS(12'h103, 5'd5, 5'd0, 3'd0));
      prog.push_back(encI(12'h103, 5'd0, 3'd0, 5'd6, 7'h03));
      prog.push_back(encI(12'h102, 5'd0, 3'd1, 5'd7, 7'h03));
      prog.push_back(encI(12'h103, 5'd0, 3'd4, 5'd8, 7'h03));
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      want = '{32'd0, 32'h12345678, 32'h78, 32'h1234, 32'h12340078, 32'h80,
               32'hFFFF_FF80, 32'hFFFF_8034, 32'h80};
      startProgram();
      step(14);
      for (int i = 1; i < 9; i++) begin
         totalChecks++;
         if (dut.regs[i] !== want[i])
            $display("[TB] FAIL ls_x%0d: got %h want %h", i, dut.regs[i], want[i]);
         else passedChecks++;
      end
      totalChecks++;
      if (dut.Memory.ramdata[64] !== 32'h80340078)
         $display("[TB] FAIL ls_word: got %h want %h", dut.Memory.ramdata[64], 32'h80340078);
      else passedChecks++;
   endtask

   task automatic test_branch_loop();
      $display("[TB] test_branch_loop");
      prog.delete();
      prog.push_back(encI(12'd10, 5'd0, 3'd0, 5'd2, 7'h13));
      prog.push_back(encI(12'd0, 5'd0, 3'd0, 5'd1, 7'h13));
      prog.push_back(encI(12'd1, 5'd1, 3'd0, 5'd1, 7'h13));
      prog.push_back(encB(13'h1FFC, 5'd2, 5'd1, 3'd1));
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      startProgram();
      step(21);
      totalChecks++;
      if (dut.pc !== 32'hC) $display("[TB] FAIL loop_pc21: got %h want %h", dut.pc, 32'hC);
      else passedChecks++;
      step(1);
      totalChecks++;
      if (dut.pc !== 32'h10) $display("[TB] FAIL loop_pc22: got %h want %h", dut.pc, 32'h10);
      else passedChecks++;
      totalChecks++;
      if (dut.regs[1] !== 32'd10) $display("[TB] FAIL loop_x1: got %h want %h", dut.regs[1], 32'd10);
      else passedChecks++;
      step(5);
      totalChecks++;
      if (dut.pc !== 32'h10) $display("[TB] FAIL loop_hold: got %h want %h", dut.pc, 32'h10);
      else passedChecks++;
   endtask

   task automatic test_jumps();
      $display("[TB] test_jumps");
      prog.delete();
      prog.push_back(encI(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
      repeat (3) prog.push_back(encI(12'd0, 5'd0, 3'd0, 5'd0, 7'h13));
      prog.push_back(encJ(21'd8, 5'd1));
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      prog.push_back(encI(12'd0, 5'd1, 3'd0, 5'd2, 7'h67));
      startProgram();
      step(5);
      totalChecks++;
      if (dut.pc !== 32'h18) $display("[TB] FAIL jal_pc: got %h want %h", dut.pc, 32'h18);
      else passedChecks++;
      totalChecks++;
      if (dut.regs[1] !== 32'h14) $display("[TB] FAIL jal_x1: got %h want %h", dut.regs[1], 32'h14);
      else passedChecks++;
      totalChecks++;
      if (dut.regs[0] !== 32'd0) $display("[TB] FAIL x0_write: got %h want %h", dut.regs[0], 32'd0);
      else passedChecks++;
      step(1);
      totalChecks++;
      if (dut.pc !== 32'h14) $display("[TB] FAIL jalr_pc: got %h want %h", dut.pc, 32'h14);
      else passedChecks++;
      totalChecks++;
      if (dut.regs[2] !== 32'h1C) $display("[TB] FAIL jalr_x2: got %h want %h", dut.regs[2], 32'h1C);
      else passedChecks++;
      step(3);
      totalChecks++;
      if (dut.pc !== 32'h14) $display("[TB] FAIL jump_hold: got %h want %h", dut.pc, 32'h14);
      else passedChecks++;
   endtask

   task automatic test_upper_nop();
      int nonZero;
      $display("[TB] test_upper_nop");
      prog.delete();
      repeat (8) prog.push_back(32'd0);
      prog.push_back(encU(20'h1, 5'd5, 7'h17));
      prog.push_back(32'h0000_0073);
      prog.push_back(32'h0000_000F);
      prog.push_back(32'h0010_0073);
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      startProgram();
      step(9);
      totalChecks++;
      if (dut.regs[5] !== 32'h1020) $display("[TB] FAIL auipc_x5: got %h want %h", dut.regs[5], 32'h1020);
      else passedChecks++;
      step(1);
      totalChecks++;
      if (dut.pc !== 32'h28) $display("[TB] FAIL ecall_pc: got %h want %h", dut.pc, 32'h28);
      else passedChecks++;
      step(2);
      nonZero = 0;
      for (int i = 0; i < 32; i++) if (i != 5 && dut.regs[i] !== 32'd0) nonZero++;
      totalChecks++;
      if (nonZero != 0 || dut.regs[5] !== 32'h1020)
         $display("[TB] FAIL nop_regs: got %0d stray writes want 0", nonZero);
      else passedChecks++;
      totalChecks++;
      if (dut.pc !== 32'h30) $display("[TB] FAIL nop_pc: got %h want %h", dut.pc, 32'h30);
      else passedChecks++;
      step(10);
      totalChecks++;
      if (dut.pc !== 32'h30) $display("[TB] FAIL self_branch: got %h want %h", dut.pc, 32'h30);
      else passedChecks++;
   endtask

   // Random straight-line programs; the model tracks registers and a byte-addressed data window at 0x400.
   task automatic test_random(input int round);
      logic [31:0] m [0:31];
      logic [7:0]  mb [0:255];
      logic [31:0] v, res, b;
      logic [11:0] imm;
      int rd, rs1, rs2, f3, off, hb, wb, kind, sel;
      bit alt;
      $display("[TB] test_random round %0d", round);
      prog.delete();
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      for (int i = 0; i < 256; i++) mb[i] = 8'd0;
      for (int r = 1; r <= 8; r++) begin
         v = $urandom;
         prog.push_back(encU(v[31:12] + {19'd0, v[11]}, 5'(r), 7'h37));
         prog.push_back(encI(v[11:0], 5'(r), 3'd0, 5'(r), 7'h13));
         m[r] = v;
      end
      for (int k = 0; k < 40; k++) begin
         rd = $urandom_range(0, 15);
         rs1 = $urandom_range(0, 15);
         rs2 = $urandom_range(0, 15);
         kind = $urandom_range(0, 2);
         f3 = $urandom_range(0, 7);
         if (kind == 0) begin
            alt = (f3 == 0 || f3 == 5) ? bit'($urandom_range(0, 1)) : 1'b0;
            prog.push_back(encR(alt ? 7'h20 : 7'h00, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33));
            res = refAlu(f3, alt, m[rs1], m[rs2]);
            if (rd != 0) m[rd] = res;
         end else if (kind == 1) begin
            alt = 1'b0;
            if (f3 == 1 || f3 == 5) begin
               alt = (f3 == 5) ? bit'($urandom_range(0, 1)) : 1'b0;
               imm = {alt ? 7'h20 : 7'h00, 5'($urandom_range(0, 31))};
            end else begin
               imm = 12'($urandom);
            end
            prog.push_back(encI(imm, 5'(rs1), 3'(f3), 5'(rd), 7'h13));
            b = sext12(imm);
            res = refAlu(f3, alt, m[rs1], b);
            if (rd != 0) m[rd] = res;
         end else begin
            off = $urandom_range(0, 255);
            hb = off & 'hFE;
            wb = off & 'hFC;
            imm = 12'(12'h400 + off);
            if ($urandom_range(0, 1) == 1) begin
               sel = $urandom_range(0, 2);
               prog.push_back(encS(imm, 5'(rs2), 5'd0, 3'(sel)));
               v = m[rs2];
               if (sel == 0) mb[off] = v[7:0];
               else if (sel == 1) begin mb[hb] = v[7:0]; mb[hb+1] = v[15:8]; end
               else begin
                  mb[wb] = v[7:0]; mb[wb+1] = v[15:8]; mb[wb+2] = v[23:16]; mb[wb+3] = v[31:24];
               end
            end else begin
               sel = $urandom_range(0, 4);
               if (sel == 0)      begin f3 = 0; res = {{24{mb[off][7]}}, mb[off]}; end
               else if (sel == 1) begin f3 = 1; res = {{16{mb[hb+1][7]}}, mb[hb+1], mb[hb]}; end
               else if (sel == 2) begin f3 = 2; res = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]}; end
               else if (sel == 3) begin f3 = 4; res = {24'd0, mb[off]}; end
               else               begin f3 = 5; res = {16'd0, mb[hb+1], mb[hb]}; end
               prog.push_back(encI(imm, 5'd0, 3'(f3), 5'(rd), 7'h03));
               if (rd != 0) m[rd] = res;
            end
         end
      end
      prog.push_back(encB(13'd0, 5'd0, 5'd0, 3'd0));
      startProgram();
      step(prog.size() + 3);
      for (int i = 0; i < 16; i++) begin
         totalChecks++;
         if (dut.regs[i] !== m[i])
            $display("[TB] FAIL rand%0d_x%0d: got %h want %h", round, i, dut.regs[i], m[i]);
         else passedChecks++;
      end
      for (int w = 0; w < 64; w += 8) begin
         v = {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
         totalChecks++;
         if (dut.Memory.ramdata[256 + w] !== v)
            $display("[TB] FAIL rand%0d_mem%0d: got %h want %h", round, w, dut.Memory.ramdata[256 + w], v);
         else passedChecks++;
      end
   endtask

   // Test sequence followed by the single summary line.
   initial begin
      clr = 1'b1;
      test_reset();
      test_alu();
      test_load_store();
      test_branch_loop();
      test_jumps();
      test_upper_nop();
      for (int r = 0; r < 4; r++) test_random(r);
      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
